wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Round-robin arbiter that shares the single 8-bit wishbone slave bus between NM wishbone masters.
- Typical masters: the CPU-side bus bridge, a DMA engine, and a configuration sequencer.
- Holds one grant for the whole transaction and registers the outgoing strobe, address, rw and data.
- Routes the slave ack back to the granted master only, and aborts a hung transaction with a watchdog.

Parameters:
NM, 2, number of masters (2..4)
WDOG, 32, cycles in BUSY without ack before a forced abort (must exceed the masters' 16-clock timeout)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-low
m_stb  in  NM  per-master strobe; held high until ack or master timeout
m_adr  in  8*NM  per-master address; master i uses bits [8i+7:8i]
m_rw  in  NM  per-master direction; 1 = write, 0 = read
m_dat  in  8*NM  per-master write data
m_ack  out  NM  per-master ack
m_dati  out  8  read data broadcast to all masters, equal to s_dati
s_stb  out  1  slave strobe
s_adr  out  8  slave address
s_rw  out  1  slave direction
s_dato  out  8  slave write data
s_ack  in  1  slave ack
s_dati  in  8  slave read data
gnt  out  NM  one-hot grant; all zeros when idle
busy  out  1  high in BUSY and GAP states
to_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (rst low at a clock edge): state IDLE, gnt=0, s_stb=0, s_adr=0, s_rw=0, s_dato=0, busy=0, to_err=0, ptr=0, watchdog count=0.
- Reset applies in every state, including mid-transaction; no ack is issued for the aborted transaction.
- States: IDLE, BUSY, GAP.
- IDLE:
  - If any m_stb is high, the winner is the first requester found searching from index ptr upward, wrapping mod NM.
  - At the next edge: gnt=onehot(winner), s_adr/s_rw/s_dato latched from the winner, s_stb=1, ptr=(winner+1) mod NM, count=0, state BUSY.
  - Latency from m_stb rising to s_stb high: 1 clock.
- BUSY:
  - m_ack[i] = s_ack & s_stb & gnt[i], combinational; zero added ack latency.
  - m_dati = s_dati, combinational; the master samples it with its ack.
  - s_adr/s_rw/s_dato stay stable for the whole transaction.
  - On s_ack high: next edge s_stb=0, state GAP.
  - Granted master drops m_stb without ack (master timeout): next edge s_stb=0, state GAP, no to_err.
  - count reaches WDOG-1 with no ack and m_stb still high: next edge s_stb=0, to_err=1 for one cycle, state GAP.
  - Priority when these coincide in one cycle: ack, then master drop, then watchdog.
  - s_ack while s_stb is low, or in any state other than BUSY, is ignored and produces no m_ack.
- GAP:
  - One cycle; s_stb=0, gnt held.
  - Lets the acked master drop its strobe before the next grant, so the same transaction is never re-granted.
  - Next edge: gnt=0, state IDLE.
- Transaction spacing: minimum 3 clocks from one s_stb rise to the next (BUSY of 1+ cycles, then GAP, then IDLE).
- Fairness: a master continuously requesting cannot win twice in a row while another master is requesting.
- busy = (state != IDLE).

Test Plan:
- Single master 0 write, adr=0x12, dat=0xA5; slave acks 2 cycles after s_stb -> s_stb high 1 clock after m_stb; s_adr=0x12, s_rw=1, s_dato=0xA5; m_ack[0] coincides with s_ack; m_ack[1]=0; gnt returns to 0 after GAP.
- Masters 0 and 1 request in the same cycle from reset -> master 0 granted first, then master 1. Master 1 read returns s_dati=0x3C on m_dati with m_ack[1].
- Both masters request continuously, slave acks in 1 cycle -> grants alternate 0,1,0,1; s_stb rises every 3 clocks.
- Master 1 granted, slave never acks, master drops m_stb after 16 clocks -> s_stb low next edge; to_err stays 0; m_ack never asserted.
- Slave never acks and master holds m_stb -> after WDOG=32 BUSY cycles: s_stb=0 and to_err pulses for exactly one cycle; arbiter returns to IDLE 2 clocks later.
- rst low during BUSY -> next edge all outputs at reset values; a spurious s_ack afterwards produces no m_ack.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbiter sharing one 8-bit wishbone slave among NM masters
module wb_arbiter #(
  parameter int NM   = 2,
  parameter int WDOG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NM-1:0]   m_stb,
  input  logic [8*NM-1:0] m_adr,
  input  logic [NM-1:0]   m_rw,
  input  logic [8*NM-1:0] m_dat,
  output logic [NM-1:0]   m_ack,
  output logic [7:0]      m_dati,
  output logic            s_stb,
  output logic [7:0]      s_adr,
  output logic            s_rw,
  output logic [7:0]      s_dato,
  input  logic            s_ack,
  input  logic [7:0]      s_dati,
  output logic [NM-1:0]   gnt,
  output logic            busy,
  output logic            to_err
);
  localparam int PW = $clog2(NM);
  localparam int CW = $clog2(WDOG) + 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]    state;
  logic [PW-1:0] ptr, win, idx;
  logic          found, own_stb;
  logic [CW-1:0] cnt;
  logic [7:0]    adr_a [NM];
  logic [7:0]    dat_a [NM];

  for (genvar i = 0; i < NM; i++) begin : g_split
    assign adr_a[i] = m_adr[8*i +: 8];
    assign dat_a[i] = m_dat[8*i +: 8];
  end

  assign own_stb = |(m_stb & gnt);
  assign m_ack   = {NM{s_ack & s_stb}} & gnt;
  assign m_dati  = s_dati;
  assign busy    = state != IDLE;

  // first requester at or after ptr, wrapping round the master list
  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = '0;
    for (int k = 0; k < NM; k++) begin
      idx = PW'((int'(ptr) + k) % NM);
      if (!found && m_stb[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // grant, hold for the transaction, then one idle GAP cycle before re-arbitrating
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      gnt    <= '0;
      s_stb  <= 1'b0;
      s_adr  <= '0;
      s_rw   <= 1'b0;
      s_dato <= '0;
      to_err <= 1'b0;
      ptr    <= '0;
      cnt    <= '0;
    end else begin
      to_err <= 1'b0;
      if (state == IDLE) begin
        if (found) begin
          state  <= BUSY;
          gnt    <= NM'(1) << win;
          s_stb  <= 1'b1;
          s_adr  <= adr_a[win];
          s_rw   <= m_rw[win];
          s_dato <= dat_a[win];
          ptr    <= (win == PW'(NM-1)) ? '0 : win + 1'b1;
          cnt    <= '0;
        end
      end else if (state == BUSY) begin
        if (s_ack || !own_stb || cnt == CW'(WDOG-1)) begin
          state  <= GAP;
          s_stb  <= 1'b0;
          to_err <= !s_ack && own_stb;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        state <= IDLE;
        gnt   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and randomized checks of wb_arbiter against a transaction-level model
module tb_wb_arbiter;
  localparam int NM = 2;
  localparam int WDOG = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NM-1:0]   m_stb = '0, m_rw = '0;
  logic [8*NM-1:0] m_adr = '0, m_dat = '0;
  logic            s_ack = 1'b0;
  logic [7:0]      s_dati = '0;
  logic [NM-1:0]   m_ack, gnt;
  logic [7:0]      m_dati, s_adr, s_dato;
  logic            s_stb, s_rw, busy, to_err;

  always #5 clk = ~clk;

  wb_arbiter #(.NM(NM), .WDOG(WDOG)) dut (
    .clk(clk), .rst(rst), .m_stb(m_stb), .m_adr(m_adr), .m_rw(m_rw), .m_dat(m_dat),
    .m_ack(m_ack), .m_dati(m_dati), .s_stb(s_stb), .s_adr(s_adr), .s_rw(s_rw),
    .s_dato(s_dato), .s_ack(s_ack), .s_dati(s_dati), .gnt(gnt), .busy(busy), .to_err(to_err)
  );

  int errors = 0, checks = 0;
  int owner = -1, age = 0, ptr = 0, cyc_no = 0;
  bit in_gap = 0;
  logic [7:0] e_adr = '0, e_dat = '0;
  logic e_rw = 1'b0, e_err = 1'b0, prev_stb = 1'b0, rose = 1'b0;
  bit auto_drop = 0, auto_req = 0, mto = 0, rnd = 0;
  int slave_mode = 0;
  int held [NM] = '{default: 0};

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NM-1:0] oh(int o);
    return o < 0 ? '0 : NM'(1) << o;
  endfunction

  // owner = granted master (-1 none); in_gap marks the idle cycle after a transaction ends
  task automatic model_step();
    if (!rst) begin
      owner = -1; in_gap = 0; age = 0; ptr = 0;
      e_adr = '0; e_dat = '0; e_rw = 1'b0; e_err = 1'b0;
    end else begin
      e_err = 1'b0;
      if (owner < 0) begin
        for (int k = 0; k < NM; k++)
          if (owner < 0 && m_stb[(ptr + k) % NM]) owner = (ptr + k) % NM;
        if (owner >= 0) begin
          e_adr = m_adr[8*owner +: 8]; e_dat = m_dat[8*owner +: 8]; e_rw = m_rw[owner];
          ptr = (owner + 1) % NM; age = 0;
        end
      end else if (!in_gap) begin
        if (s_ack || !m_stb[owner]) in_gap = 1;
        else if (age == WDOG - 1) begin in_gap = 1; e_err = 1'b1; end
        else age++;
      end else begin
        owner = -1; in_gap = 0;
      end
    end
  endtask

  task automatic cyc();
    logic [NM-1:0] ack, was;
    #1;
    ack = (owner >= 0 && !in_gap && s_ack) ? oh(owner) : '0;
    chk("m_ack", m_ack, ack);
    chk("m_dati", m_dati, s_dati);
    was = m_stb;
    model_step();
    @(posedge clk); #1;
    cyc_no++;
    chk("gnt", gnt, oh(owner));
    chk("s_stb", s_stb, owner >= 0 && !in_gap);
    chk("busy", busy, owner >= 0);
    chk("to_err", to_err, e_err);
    chk("s_adr", s_adr, e_adr);
    chk("s_rw", s_rw, e_rw);
    chk("s_dato", s_dato, e_dat);
    rose = s_stb && !prev_stb;
    prev_stb = s_stb;
    for (int i = 0; i < NM; i++) begin
      if (auto_drop && ack[i]) begin
        m_stb[i] = 1'b0; held[i] = 0;
      end else if (m_stb[i]) begin
        held[i]++;
        if (mto && held[i] >= 16) begin m_stb[i] = 1'b0; held[i] = 0; end
      end else if (auto_req && !was[i] && (!rnd || $urandom_range(0, 2) == 0)) begin
        m_stb[i] = 1'b1; held[i] = 0;
        if (rnd) begin
          m_adr[8*i +: 8] = 8'($urandom); m_dat[8*i +: 8] = 8'($urandom); m_rw[i] = 1'($urandom);
        end
      end
    end
    if (slave_mode == 1) s_ack = owner >= 0 && !in_gap;
    else if (slave_mode == 2) begin s_ack = $urandom_range(0, 2) == 0; s_dati = 8'($urandom); end
    if (rnd) rst = $urandom_range(0, 149) != 0;
  endtask

  initial begin
    int last, lastc, n, errs, hi, w;
    rst = 1'b0;
    cyc(); cyc();
    chk("rst_gnt", gnt, 0); chk("rst_stb", s_stb, 0); chk("rst_busy", busy, 0);
    rst = 1'b1;
    // single master 0 write, slave acks 2 cycles after the strobe
    m_adr[7:0] = 8'h12; m_dat[7:0] = 8'hA5; m_rw[0] = 1'b1; m_stb = 2'b01;
    cyc();
    chk("t1_stb", s_stb, 1); chk("t1_adr", s_adr, 8'h12); chk("t1_rw", s_rw, 1); chk("t1_dat", s_dato, 8'hA5);
    cyc();
    s_ack = 1'b1; #1;
    chk("t1_ack", m_ack, 2'b01);
    cyc();
    chk("t1_gap_gnt", gnt, 2'b01); chk("t1_gap_stb", s_stb, 0);
    m_stb = '0; s_ack = 1'b0;
    cyc();
    chk("t1_idle_gnt", gnt, 0);
    // simultaneous requests from reset: master 0 then master 1 (read)
    rst = 1'b0; cyc(); rst = 1'b1;
    m_adr[15:8] = 8'h34; m_rw = 2'b01; m_stb = 2'b11;
    cyc();
    chk("t2_first", gnt, 2'b01);
    s_ack = 1'b1; cyc();
    m_stb[0] = 1'b0; s_ack = 1'b0;
    cyc(); cyc();
    chk("t2_second", gnt, 2'b10); chk("t2_adr", s_adr, 8'h34); chk("t2_rw", s_rw, 0);
    s_dati = 8'h3C; s_ack = 1'b1; #1;
    chk("t2_ack", m_ack, 2'b10); chk("t2_dati", m_dati, 8'h3C);
    cyc();
    m_stb = '0; s_ack = 1'b0;
    cyc();
    // continuous requests, 1-cycle slave: alternating grants every 3 clocks
    auto_drop = 1; auto_req = 1; slave_mode = 1; m_stb = 2'b11;
    last = -1; lastc = 0; n = 0;
    repeat (15) begin
      cyc();
      if (rose) begin
        if (last >= 0) begin
          chk("t3_spacing", cyc_no - lastc, 3);
          chk("t3_alternate", gnt, oh(1 - last));
        end
        last = gnt[1] ? 1 : 0; lastc = cyc_no; n++;
      end
    end
    chk("t3_grants", n >= 4, 1);
    auto_req = 0; slave_mode = 0; s_ack = 1'b0; m_stb = '0; auto_drop = 0;
    repeat (3) cyc();
    // master 1 times out after 16 clocks with no slave ack
    held = '{default: 0}; mto = 1; m_stb = 2'b10; errs = 0;
    cyc();
    chk("t4_gnt", gnt, 2'b10);
    repeat (20) begin cyc(); errs += int'(to_err); end
    chk("t4_noerr", errs, 0); chk("t4_idle", busy, 0); chk("t4_dropped", m_stb, 0);
    mto = 0;
    // watchdog abort after WDOG busy cycles
    m_stb = 2'b01;
    cyc();
    chk("t5_gnt", gnt, 2'b01);
    hi = 1; w = 0;
    while (!to_err && w < 40) begin cyc(); hi += int'(s_stb); w++; end
    chk("t5_err", to_err, 1); chk("t5_busy_cycles", hi, WDOG); chk("t5_stb", s_stb, 0);
    m_stb = '0;
    cyc();
    chk("t5_pulse", to_err, 0); chk("t5_idle", busy, 0);
    // reset mid-transaction, then a stray slave ack
    m_stb = 2'b01;
    cyc(); cyc();
    rst = 1'b0; m_stb = '0;
    cyc();
    chk("t6_gnt", gnt, 0); chk("t6_stb", s_stb, 0); chk("t6_busy", busy, 0); chk("t6_adr", s_adr, 0);
    rst = 1'b1; s_ack = 1'b1; #1;
    chk("t6_noack", m_ack, 0);
    cyc();
    s_ack = 1'b0;
    // randomized traffic with random slave acks, master timeouts and resets
    rnd = 1; auto_drop = 1; auto_req = 1; mto = 1; slave_mode = 2;
    repeat (3000) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
